// File: rtl/overture_imem_responder_if.sv
// Handshake bundle between the program loader / CPU fetch port (master)
// and the instruction-memory responder (slave).
interface overture_imem_responder_if #(
  parameter int ADDR_W = 8
);
  logic              load_start;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_ovf;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [7:0]        fetch_instr;
  logic [ADDR_W-1:0] prog_len;

  modport master (
    output load_start, load_valid, load_data, load_last,
    output fetch_req, fetch_addr,
    input  load_ready, load_ovf, fetch_ready, fetch_valid, fetch_instr, prog_len
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last,
    input  fetch_req, fetch_addr,
    output load_ready, load_ovf, fetch_ready, fetch_valid, fetch_instr, prog_len
  );
endinterface

// File: rtl/overture_imem_responder.sv
// Instruction-memory responder for Overture-style 8-bit CPUs.
// A program is streamed in byte by byte, then CPU fetches are answered one
// cycle after acceptance. Fetches beyond the loaded program return HALT (C0).
// Optional feature macro: OVERTURE_IMEM_WRAP_EN -- out-of-range fetches wrap
// modulo the program length so the loaded program loops.
module overture_imem_responder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8
) (
  input logic                     clk,
  input logic                     reset,
  overture_imem_responder_if.slave bus
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WPTR_W = ADDR_W + 1;
  localparam logic [7:0] HALT = 8'hC0;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t            state;
  logic [WPTR_W-1:0] wptr;
  logic [ADDR_W-1:0] prog_len;
  logic              load_ovf;
  logic              fetch_valid;
  logic [7:0]        fetch_instr;
  logic [7:0]        mem [DEPTH];

  logic              load_ready;
  logic              fetch_ready;
  logic              beat_accept;
  logic              fetch_accept;
  logic              last_slot;
  logic [7:0]        lookup;

  // A load_start cycle never accepts a beat: it only restarts the load.
  assign load_ready   = (state == LOADING) && (wptr < WPTR_W'(DEPTH));
  assign fetch_ready  = (state != LOADING);
  assign beat_accept  = bus.load_valid && load_ready && !bus.load_start;
  assign fetch_accept = bus.fetch_req && fetch_ready;
  assign last_slot    = (wptr == WPTR_W'(DEPTH - 1));

`ifdef OVERTURE_IMEM_WRAP_EN
  logic [ADDR_W-1:0] wrap_addr;
  assign wrap_addr = (prog_len != '0) ? (bus.fetch_addr % prog_len) : '0;
`endif

  // Instruction lookup for the address currently presented on the fetch port.
  always_comb begin
    lookup = HALT;
    if (bus.fetch_addr < prog_len) begin
      lookup = mem[bus.fetch_addr[IDX_W-1:0]];
    end
`ifdef OVERTURE_IMEM_WRAP_EN
    else if (prog_len != '0) begin
      lookup = mem[wrap_addr[IDX_W-1:0]];
    end
`endif
  end

  // Program storage; intentionally not reset since prog_len gates all reads.
  always_ff @(posedge clk) begin
    if (beat_accept) begin
      mem[wptr[IDX_W-1:0]] <= bus.load_data;
    end
  end

  // Control FSM plus the registered load bookkeeping and fetch response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      wptr        <= '0;
      prog_len    <= '0;
      load_ovf    <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_instr <= 8'h00;
    end else begin
      fetch_valid <= fetch_accept;
      if (fetch_accept) begin
        fetch_instr <= lookup;
      end

      if (bus.load_start) begin
        state    <= LOADING;
        wptr     <= '0;
        prog_len <= '0;
        load_ovf <= 1'b0;
      end else if (beat_accept) begin
        wptr     <= wptr + WPTR_W'(1);
        prog_len <= ADDR_W'(wptr + WPTR_W'(1));
        if (bus.load_last) begin
          state <= READY;
        end else if (last_slot) begin
          state    <= READY;
          load_ovf <= 1'b1;
        end
      end
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.load_ovf    = load_ovf;
  assign bus.fetch_ready = fetch_ready;
  assign bus.fetch_valid = fetch_valid;
  assign bus.fetch_instr = fetch_instr;
  assign bus.prog_len    = prog_len;

endmodule

// File: tb/tb_overture_imem_responder.sv
// Directed bench for overture_imem_responder: a DEPTH=64 instance for the
// main scenarios and a DEPTH=4 instance for the overflow scenario.
module tb_overture_imem_responder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  overture_imem_responder_if #(.ADDR_W(8)) bus ();
  overture_imem_responder_if #(.ADDR_W(8)) sbus ();

  overture_imem_responder #(.DEPTH(64), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  overture_imem_responder #(.DEPTH(4), .ADDR_W(8)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to one time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic idle_inputs();
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = 0; bus.load_last = 0;
    bus.fetch_req = 0; bus.fetch_addr = 0;
    sbus.load_start = 0; sbus.load_valid = 0; sbus.load_data = 0; sbus.load_last = 0;
    sbus.fetch_req = 0; sbus.fetch_addr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    check("rst_prog_len", bus.prog_len, 8'd0);
    check("rst_load_ready", {7'd0, bus.load_ready}, 8'd0);
    check("rst_load_ovf", {7'd0, bus.load_ovf}, 8'd0);
    check("rst_fetch_valid", {7'd0, bus.fetch_valid}, 8'd0);
    check("rst_fetch_instr", bus.fetch_instr, 8'h00);
    check("rst_fetch_ready", {7'd0, bus.fetch_ready}, 8'd1);
    reset = 0;
    step();
  endtask

  task automatic test_empty_fetch();
    bus.fetch_req = 1; bus.fetch_addr = 8'd0;
    step();
    check("empty_fetch_valid", {7'd0, bus.fetch_valid}, 8'd1);
    check("empty_fetch_instr", bus.fetch_instr, 8'hC0);
    bus.fetch_req = 0;
    step();
    check("empty_idle_valid", {7'd0, bus.fetch_valid}, 8'd0);
    check("empty_idle_instr_hold", bus.fetch_instr, 8'hC0);
  endtask

  task automatic test_load_and_fetch();
    logic [7:0] prog [4];
    prog[0] = 8'h03; prog[1] = 8'h45; prog[2] = 8'h42; prog[3] = 8'hC0;
    bus.load_start = 1;
    step();
    bus.load_start = 0;
    check("ld_start_load_ready", {7'd0, bus.load_ready}, 8'd1);
    check("ld_start_fetch_ready", {7'd0, bus.fetch_ready}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1; bus.load_data = prog[i]; bus.load_last = (i == 3);
      step();
    end
    bus.load_valid = 0; bus.load_last = 0;
    check("ld_prog_len", bus.prog_len, 8'd4);
    check("ld_ready_after", {7'd0, bus.load_ready}, 8'd0);
    check("ld_fetch_ready", {7'd0, bus.fetch_ready}, 8'd1);
    check("ld_ovf", {7'd0, bus.load_ovf}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      bus.fetch_req = 1; bus.fetch_addr = 8'(i);
      step();
      check("b2b_valid", {7'd0, bus.fetch_valid}, 8'd1);
      check("b2b_instr", bus.fetch_instr, prog[i]);
    end
    bus.fetch_req = 0;
    step();
    check("b2b_end_valid", {7'd0, bus.fetch_valid}, 8'd0);
  endtask

  task automatic test_out_of_range();
    logic [7:0] want5, want4;
`ifdef OVERTURE_IMEM_WRAP_EN
    want5 = 8'h45; want4 = 8'h03;
`else
    want5 = 8'hC0; want4 = 8'hC0;
`endif
    bus.fetch_req = 1; bus.fetch_addr = 8'd5;
    step();
    check("oor_addr5", bus.fetch_instr, want5);
    bus.fetch_addr = 8'd4;
    step();
    check("oor_addr4", bus.fetch_instr, want4);
    bus.fetch_addr = 8'd255;
    step();
    check("oor_addr255", bus.fetch_instr, 8'hC0);
    bus.fetch_req = 0;
    step();
  endtask

  task automatic test_overflow();
    logic [7:0] want4;
    sbus.load_start = 1;
    step();
    sbus.load_start = 0;
    for (int i = 0; i < 5; i++) begin
      sbus.load_valid = 1; sbus.load_data = 8'h10 + 8'(i); sbus.load_last = 0;
      check("ovf_load_ready", {7'd0, sbus.load_ready}, (i < 4) ? 8'd1 : 8'd0);
      step();
    end
    sbus.load_valid = 0;
    check("ovf_flag", {7'd0, sbus.load_ovf}, 8'd1);
    check("ovf_prog_len", sbus.prog_len, 8'd4);
    check("ovf_fetch_ready", {7'd0, sbus.fetch_ready}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      sbus.fetch_req = 1; sbus.fetch_addr = 8'(i);
      step();
      check("ovf_mem", sbus.fetch_instr, 8'h10 + 8'(i));
    end
`ifdef OVERTURE_IMEM_WRAP_EN
    want4 = 8'h10;
`else
    want4 = 8'hC0;
`endif
    sbus.fetch_addr = 8'd4;
    step();
    check("ovf_addr4", sbus.fetch_instr, want4);
    sbus.fetch_req = 0;
    sbus.load_start = 1;
    step();
    sbus.load_start = 0;
    check("ovf_cleared", {7'd0, sbus.load_ovf}, 8'd0);
    check("ovf_restart_len", sbus.prog_len, 8'd0);
  endtask

  task automatic test_reset_mid_load();
    bus.load_start = 1;
    step();
    bus.load_start = 0;
    for (int i = 0; i < 2; i++) begin
      bus.load_valid = 1; bus.load_data = 8'hA0 + 8'(i); bus.load_last = 0;
      step();
    end
    bus.load_valid = 0;
    check("mid_len_before", bus.prog_len, 8'd2);
    reset = 1;
    #1;
    check("mid_rst_len", bus.prog_len, 8'd0);
    check("mid_rst_load_ready", {7'd0, bus.load_ready}, 8'd0);
    step();
    reset = 0;
    check("mid_rst_fetch_ready", {7'd0, bus.fetch_ready}, 8'd1);
    bus.fetch_req = 1; bus.fetch_addr = 8'd0;
    step();
    bus.fetch_req = 0;
    check("mid_rst_fetch0", bus.fetch_instr, 8'hC0);
    bus.load_start = 1;
    step();
    bus.load_start = 0;
    bus.load_valid = 1; bus.load_data = 8'h03; bus.load_last = 0;
    step();
    bus.load_data = 8'h45; bus.load_last = 1;
    step();
    bus.load_valid = 0; bus.load_last = 0;
    check("reload_len", bus.prog_len, 8'd2);
  endtask

  task automatic test_reset_mid_fetch();
    bus.fetch_req = 1; bus.fetch_addr = 8'd0;
    step();
    bus.fetch_req = 0;
    check("mf_valid_before", {7'd0, bus.fetch_valid}, 8'd1);
    check("mf_instr_before", bus.fetch_instr, 8'h03);
    reset = 1;
    #1;
    check("mf_valid_dropped", {7'd0, bus.fetch_valid}, 8'd0);
    step();
    reset = 0;
    bus.load_start = 1;
    step();
    bus.load_start = 0;
    bus.load_valid = 1; bus.load_data = 8'h03; bus.load_last = 0;
    step();
    bus.load_data = 8'h45; bus.load_last = 1;
    step();
    bus.load_valid = 0; bus.load_last = 0;
  endtask

  task automatic test_start_with_fetch();
    bus.fetch_req = 1; bus.fetch_addr = 8'd1; bus.load_start = 1;
    step();
    bus.fetch_req = 0; bus.load_start = 0;
    check("sf_valid", {7'd0, bus.fetch_valid}, 8'd1);
    check("sf_instr", bus.fetch_instr, 8'h45);
    check("sf_fetch_ready", {7'd0, bus.fetch_ready}, 8'd0);
    check("sf_prog_len", bus.prog_len, 8'd0);
    bus.fetch_req = 1; bus.fetch_addr = 8'd0;
    step();
    bus.fetch_req = 0;
    check("sf_blocked_valid", {7'd0, bus.fetch_valid}, 8'd0);
    check("sf_instr_hold", bus.fetch_instr, 8'h45);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 0;
    idle_inputs();
    test_reset();
    test_empty_fetch();
    test_load_and_fetch();
    test_out_of_range();
    test_overflow();
    test_reset_mid_load();
    test_reset_mid_fetch();
    test_start_with_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
